// File: rtl/text_writer.sv
// Character-stream text writer: turns printable codes and CR/LF/BS/FF controls into text memory writes.
// Optional macro TEXT_WRITER_TAB_EN enables 0x09 tab stops every 8 columns.
module text_writer #(
    parameter int         COLUMNS   = 100,
    parameter int         LINES     = 75,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [7:0]  write_data,
    output logic [12:0] write_address,
    output logic        write_enable,
    output logic [6:0]  cursor_col,
    output logic [6:0]  cursor_line,
    output logic        busy
);

    localparam logic [6:0]  LAST_COL  = 7'(COLUMNS - 1);
    localparam logic [6:0]  LAST_LINE = 7'(LINES - 1);
    localparam logic [12:0] COL_STEP  = 13'(COLUMNS);
    localparam logic [12:0] LAST_ADDR = 13'(COLUMNS * LINES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state, state_next;
    logic [6:0]  col, col_next, line, line_next;
    logic [12:0] base, base_next, clr_addr, clr_next;
    logic        we_next;
    logic [7:0]  wd_next;
    logic [12:0] wa_next;
    logic        accept;
    logic [6:0]  adv_line;
    logic [12:0] adv_base, cur_addr;
`ifdef TEXT_WRITER_TAB_EN
    logic [7:0]  tab_col;
`endif

    assign char_ready  = (state == IDLE);
    assign busy        = (state == CLEAR);
    assign accept      = char_valid & char_ready;
    assign cursor_col  = col;
    assign cursor_line = line;
    assign cur_addr    = base + {6'd0, col};
`ifdef TEXT_WRITER_TAB_EN
    assign tab_col     = {1'b0, col[6:3], 3'b000} + 8'd8;
`endif

    // Line base steps by COLUMNS alongside the line number so no multiplier is needed.
    always_comb begin
        if (line == LAST_LINE) begin
            adv_line = 7'd0;
            adv_base = 13'd0;
        end else begin
            adv_line = line + 7'd1;
            adv_base = base + COL_STEP;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        line_next  = line;
        base_next  = base;
        clr_next   = clr_addr;
        we_next    = 1'b0;
        wd_next    = write_data;
        wa_next    = write_address;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        we_next = 1'b1;
                        wd_next = char_data;
                        wa_next = cur_addr;
                        if (col == LAST_COL) begin
                            col_next  = 7'd0;
                            line_next = adv_line;
                            base_next = adv_base;
                        end else begin
                            col_next = col + 7'd1;
                        end
                    end else begin
                        case (char_data)
                            8'h0D: col_next = 7'd0;
                            8'h0A: begin
                                col_next  = 7'd0;
                                line_next = adv_line;
                                base_next = adv_base;
                            end
                            8'h08: begin
                                if (col != 7'd0) begin
                                    col_next = col - 7'd1;
                                    we_next  = 1'b1;
                                    wd_next  = FILL_CHAR;
                                    wa_next  = cur_addr - 13'd1;
                                end
                            end
                            // First fill write issues on the acceptance edge to keep one-cycle latency.
                            8'h0C: begin
                                state_next = CLEAR;
                                we_next    = 1'b1;
                                wd_next    = FILL_CHAR;
                                wa_next    = 13'd0;
                                clr_next   = 13'd1;
                            end
`ifdef TEXT_WRITER_TAB_EN
                            8'h09: begin
                                if (tab_col >= 8'(COLUMNS)) begin
                                    col_next  = 7'd0;
                                    line_next = adv_line;
                                    base_next = adv_base;
                                end else begin
                                    col_next = tab_col[6:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                we_next  = 1'b1;
                wd_next  = FILL_CHAR;
                wa_next  = clr_addr;
                clr_next = clr_addr + 13'd1;
                if (clr_addr == LAST_ADDR) begin
                    state_next = IDLE;
                    col_next   = 7'd0;
                    line_next  = 7'd0;
                    base_next  = 13'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            col           <= 7'd0;
            line          <= 7'd0;
            base          <= 13'd0;
            clr_addr      <= 13'd0;
            write_enable  <= 1'b0;
            write_data    <= 8'd0;
            write_address <= 13'd0;
        end else begin
            state         <= state_next;
            col           <= col_next;
            line          <= line_next;
            base          <= base_next;
            clr_addr      <= clr_next;
            write_enable  <= we_next;
            write_data    <= wd_next;
            write_address <= wa_next;
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Randomized/directed bench for text_writer against a cursor-and-address reference model.
module tb_text_writer;
    localparam int COLUMNS = 100;
    localparam int LINES   = 75;
    localparam int TOTAL   = COLUMNS * LINES;
    localparam logic [7:0] FILL = 8'h20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_data = 8'd0;
    logic        char_valid = 1'b0;
    logic        char_ready, write_enable, busy;
    logic [7:0]  write_data;
    logic [12:0] write_address;
    logic [6:0]  cursor_col, cursor_line;

    int checks = 0;
    int errors = 0;
    int m_col = 0, m_line = 0;
    logic exp_we;
    int exp_addr;
    logic [7:0] exp_data;

    text_writer #(.COLUMNS(COLUMNS), .LINES(LINES), .FILL_CHAR(FILL)) dut (
        .clock(clock), .reset(reset), .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .write_data(write_data), .write_address(write_address),
        .write_enable(write_enable), .cursor_col(cursor_col), .cursor_line(cursor_line),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_line();
        m_col  = 0;
        m_line = (m_line + 1) % LINES;
    endtask

    // Reference behaviour for one accepted character (clear is handled separately).
    task automatic model_char(input logic [7:0] c);
        exp_we = 1'b0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_we = 1'b1; exp_addr = m_line * COLUMNS + m_col; exp_data = c;
            m_col++;
            if (m_col == COLUMNS) next_line();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h0A) begin
            next_line();
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_we = 1'b1; exp_addr = m_line * COLUMNS + m_col; exp_data = FILL;
            end
`ifdef TEXT_WRITER_TAB_EN
        end else if (c == 8'h09) begin
            if ((m_col / 8 + 1) * 8 >= COLUMNS) next_line();
            else m_col = (m_col / 8 + 1) * 8;
`endif
        end
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, ".col"}, 32'(cursor_col), 32'(m_col));
        chk({tag, ".line"}, 32'(cursor_line), 32'(m_line));
    endtask

    // One cycle: present (v,c), then check the registered result 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] c);
        char_valid = v; char_data = c;
        exp_we = 1'b0;
        if (v) model_char(c);
        @(posedge clock); #1;
        char_valid = 1'b0;
        chk("we", 32'(write_enable), 32'(exp_we));
        if (exp_we) begin
            chk("addr", 32'(write_address), 32'(exp_addr));
            chk("data", 32'(write_data), 32'(exp_data));
        end
        chk("ready", 32'(char_ready), 32'd1);
        check_cursor("cur");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        char_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_col = 0; m_line = 0;
    endtask

    task automatic goto(input int col, input int line);
        do_reset();
        for (int i = 0; i < line; i++) step(1'b1, 8'h0A);
        for (int i = 0; i < col; i++) step(1'b1, 8'($urandom_range(8'h20, 8'h7E)));
    endtask

    task automatic do_clear(input int abort_at);
        char_valid = 1'b1; char_data = 8'h0C;
        @(posedge clock); #1;
        char_valid = 1'b0;
        for (int k = 0; k < TOTAL; k++) begin
            chk("clr.we", 32'(write_enable), 32'd1);
            chk("clr.addr", 32'(write_address), 32'(k));
            chk("clr.data", 32'(write_data), 32'(FILL));
            chk("clr.busy", 32'(busy), 32'(k != TOTAL - 1));
            chk("clr.ready", 32'(char_ready), 32'(k == TOTAL - 1));
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                m_col = 0; m_line = 0;
                chk("abort.we", 32'(write_enable), 32'd0);
                chk("abort.busy", 32'(busy), 32'd0);
                check_cursor("abort");
                for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
                return;
            end
            @(posedge clock); #1;
        end
        m_col = 0; m_line = 0;
        chk("clr.end.we", 32'(write_enable), 32'd0);
        chk("clr.end.busy", 32'(busy), 32'd0);
        check_cursor("clr.end");
    endtask

    initial begin
        logic [7:0] c;
        // reset state
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst.we", 32'(write_enable), 32'd0);
        chk("rst.wd", 32'(write_data), 32'd0);
        chk("rst.wa", 32'(write_address), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(char_ready), 32'd1);
        check_cursor("rst");

        // "AB" back-to-back
        step(1'b1, 8'h41); step(1'b1, 8'h42); step(1'b0, 8'h00);

        // last cell wraps to (0,0)
        goto(99, 74);
        step(1'b1, 8'h5A);

        // backspace mid-line and at column 0
        goto(5, 3);
        step(1'b1, 8'h08);
        step(1'b1, 8'h0D);
        step(1'b1, 8'h08);

        // CR, LF, discarded code
        goto(10, 2);
        step(1'b1, 8'h0D); step(1'b1, 8'h0A); step(1'b1, 8'h80);
        step(1'b1, 8'h7F); step(1'b1, 8'h00);

        // tab (expected movement depends on the build macro)
        goto(3, 0);
        step(1'b1, 8'h09);
        goto(97, 0);
        step(1'b1, 8'h09);

        // reset wins over a simultaneous character
        goto(7, 1);
        reset = 1'b1; char_valid = 1'b1; char_data = 8'h51;
        @(posedge clock); #1;
        reset = 1'b0; char_valid = 1'b0;
        m_col = 0; m_line = 0;
        chk("rstpri.we", 32'(write_enable), 32'd0);
        check_cursor("rstpri");

        // random mix
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: c = 8'($urandom_range(8'h20, 8'h7E));
                6: c = 8'h0D;
                7: c = 8'h0A;
                8: c = 8'h08;
                default: c = 8'($urandom_range(0, 255));
            endcase
            if (c == 8'h0C) c = 8'h0B;
            step(1'($urandom_range(0, 3) != 0), c);
        end

        // full clear, then clear aborted by reset at write 100
        do_clear(-1);
        step(1'b1, 8'h41);
        goto(20, 5);
        do_clear(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter COLUMNS, default 100, characters per text line.
REQ-002 Parameter LINES, default 75, text lines per screen.
REQ-003 Parameter FILL_CHAR, default 8'h20, code written by clear and backspace.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 char_data  input  8  incoming character code.
REQ-007 char_valid  input  1  char_data valid.
REQ-008 char_ready  output  1  block can accept a character this cycle.
REQ-009 write_data  output  8  text memory write data.
REQ-010 write_address  output  13  text memory cell address, line*COLUMNS+column.
REQ-011 write_enable  output  1  one-cycle text memory write strobe.
REQ-012 cursor_col  output  7  current cursor column.
REQ-013 cursor_line  output  7  current cursor line.
REQ-014 busy  output  1  high while a clear sequence runs.

Function
REQ-015 The block SHALL have exactly two states, IDLE and CLEAR; char_ready SHALL be 1 in IDLE and 0 in CLEAR; busy SHALL equal (state==CLEAR).
REQ-016 A character SHALL be accepted only on a cycle with char_valid & char_ready; at most one per cycle.
REQ-017 Printable code 0x20-0x7E: one cycle after acceptance, write_enable=1, write_data=code, write_address=cursor address at acceptance; cursor SHALL then advance one column.
REQ-018 Column advance past COLUMNS-1 SHALL set column 0 and advance line; line advance past LINES-1 SHALL wrap to line 0 (no scrolling).
REQ-019 0x0D (CR): column SHALL become 0, line unchanged, no write.
REQ-020 0x0A (LF): column SHALL become 0 and line advance with wrap per REQ-018, no write.
REQ-021 0x08 (BS): if column>0, column SHALL decrement and FILL_CHAR SHALL be written at the new position one cycle later; if column==0, no action.
REQ-022 0x0C (FF): state SHALL go to CLEAR; FILL_CHAR SHALL be written to addresses 0 through COLUMNS*LINES-1 ascending, one per cycle, write_enable continuously high; after the last write, cursor SHALL be (0,0) and state IDLE.
REQ-023 Any other code (0x00-0x1F not listed, 0x7F, 0x80-0xFF) SHALL be accepted and discarded with no write and no cursor change.
REQ-024 write_address SHALL be formed as a registered line base (stepped by COLUMNS, reset to 0 on line wrap) plus column; no multiplier.
REQ-025 Write latency SHALL be exactly one cycle after acceptance; back-to-back characters SHALL produce back-to-back writes.
REQ-026 write_enable SHALL be 0 on every cycle not specified above; write_data/write_address are don't-care when write_enable=0.
REQ-027 cursor_col/cursor_line SHALL update on the same edge that registers the write.

Reset
REQ-028 On reset: state IDLE, cursor (0,0), line base 0, write_enable 0, write_data 0, write_address 0, busy 0.
REQ-029 Reset during CLEAR SHALL abort the clear immediately; no further writes.
REQ-030 Reset has priority over any simultaneous accepted character.

Configuration
REQ-031 Macro TEXT_WRITER_TAB_EN defined: 0x09 SHALL move column to the next multiple of 8 without writes; if that is >= COLUMNS, column 0 and line advance per REQ-018.
REQ-032 Macro TEXT_WRITER_TAB_EN undefined: 0x09 SHALL be discarded per REQ-023.

Verification
REQ-033 Reset, send "AB" back-to-back -> writes (addr 0, 8'h41), (addr 1, 8'h42) on consecutive cycles; cursor (2,0).
REQ-034 Cursor (99,74), send 'Z' -> write addr 7499, 8'h5A; cursor (0,0).
REQ-035 Cursor (5,3), send 0x08 -> write addr 304, 8'h20, cursor (4,3); at (0,3) 0x08 -> no write.
REQ-036 Send 0x0C -> busy=1, char_ready=0, 7500 writes of 8'h20 at addr 0..7499, then busy=0, cursor (0,0); reset asserted at write 100 -> writes stop, cursor (0,0).
REQ-037 Cursor (10,2), send 0x0D then 0x0A -> cursor (0,2) then (0,3), no writes; send 0x80 -> no write, no cursor change.
REQ-038 With TEXT_WRITER_TAB_EN, cursor (3,0), send 0x09 -> cursor (8,0); at (97,0) -> (0,1); without macro -> unchanged.
